// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader slice.
//   mnem_e  : 6-bit mnemonic codes (0..20 defined, 21..63 unsupported)
//   OP_*    : primary opcodes, FN_* : R-type funct codes, RT_BGEZ : REGIMM rt
//   state_e : loader FSM states
//   enc_r/enc_i/enc_j : field packers for the three instruction formats
package instr_encoder_loader_pkg;

    typedef enum logic [5:0] {
        MN_ADDU  = 6'd0,  MN_SUBU  = 6'd1,  MN_AND   = 6'd2,  MN_OR    = 6'd3,
        MN_SLL   = 6'd4,  MN_JR    = 6'd5,  MN_JALR  = 6'd6,  MN_ADDIU = 6'd7,
        MN_ANDI  = 6'd8,  MN_ORI   = 6'd9,  MN_LUI   = 6'd10, MN_LW    = 6'd11,
        MN_LBU   = 6'd12, MN_SB    = 6'd13, MN_SW    = 6'd14, MN_BEQ   = 6'd15,
        MN_BNE   = 6'd16, MN_BGEZ  = 6'd17, MN_J     = 6'd18, MN_JAL   = 6'd19,
        MN_NOP   = 6'd20
    } mnem_e;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_LBU    = 6'b100100;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FN_SLL    = 6'b000000;
    localparam logic [5:0] FN_JR     = 6'b001000;
    localparam logic [5:0] FN_JALR   = 6'b001001;
    localparam logic [5:0] FN_ADDU   = 6'b100001;
    localparam logic [5:0] FN_SUBU   = 6'b100011;
    localparam logic [5:0] FN_AND    = 6'b100100;
    localparam logic [5:0] FN_OR     = 6'b100101;

    localparam logic [4:0] RT_BGEZ   = 5'b00001;

    typedef enum logic [2:0] {
        ST_IDLE, ST_WR0, ST_WR1, ST_WR2, ST_WR3
    } state_e;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

endpackage

// File: rtl/instr_encoder_loader_encoder.sv
// Pure combinational instruction encoder.
//   mnem, rs, rt, rd, shamt, imm, target : request fields
//   word  : encoded 32-bit instruction (zero for unknown mnemonics)
//   known : high when mnem is a supported code
// Fields a given instruction does not use are encoded as zero.
module instr_field_encoder
    import instr_encoder_loader_pkg::*;
(
    input  logic [5:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        known
);

    always_comb begin
        word  = '0;
        known = 1'b1;
        case (mnem_e'(mnem))
            MN_ADDU:  word = enc_r(rs, rt, rd, 5'd0, FN_ADDU);
            MN_SUBU:  word = enc_r(rs, rt, rd, 5'd0, FN_SUBU);
            MN_AND:   word = enc_r(rs, rt, rd, 5'd0, FN_AND);
            MN_OR:    word = enc_r(rs, rt, rd, 5'd0, FN_OR);
            MN_SLL:   word = enc_r(5'd0, rt, rd, shamt, FN_SLL);
            MN_JR:    word = enc_r(rs, 5'd0, 5'd0, 5'd0, FN_JR);
            MN_JALR:  word = enc_r(rs, 5'd0, rd, 5'd0, FN_JALR);
            MN_ADDIU: word = enc_i(OP_ADDIU, rs, rt, imm);
            MN_ANDI:  word = enc_i(OP_ANDI, rs, rt, imm);
            MN_ORI:   word = enc_i(OP_ORI, rs, rt, imm);
            MN_LUI:   word = enc_i(OP_LUI, 5'd0, rt, imm);
            MN_LW:    word = enc_i(OP_LW, rs, rt, imm);
            MN_LBU:   word = enc_i(OP_LBU, rs, rt, imm);
            MN_SB:    word = enc_i(OP_SB, rs, rt, imm);
            MN_SW:    word = enc_i(OP_SW, rs, rt, imm);
            MN_BEQ:   word = enc_i(OP_BEQ, rs, rt, imm);
            MN_BNE:   word = enc_i(OP_BNE, rs, rt, imm);
            MN_BGEZ:  word = enc_i(OP_REGIMM, rs, RT_BGEZ, imm);
            MN_J:     word = enc_j(OP_J, target);
            MN_JAL:   word = enc_j(OP_JAL, target);
            MN_NOP:   word = '0;
            default:  known = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes one instruction per request and streams it big-endian into a
// byte-wide instruction memory at an auto-incrementing 9-bit pointer.
//   clk, reset          : clock, asynchronous active-high reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_*               : mnemonic and instruction fields
//   clear               : synchronous pointer clear, honoured in IDLE only
//   mem_we/addr/data    : memory byte write port, one byte per WR state
//   word_out/word_valid : last encoded word, valid pulse in WR3
//   err_unknown         : one-cycle pulse after an unsupported mnemonic
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_mnem,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_shamt,
    input  logic [15:0] req_imm,
    input  logic [25:0] req_target,
    input  logic        clear,
    output logic        mem_we,
    output logic [8:0]  mem_addr,
    output logic [7:0]  mem_data,
    output logic [31:0] word_out,
    output logic        word_valid,
    output logic        err_unknown
);

    state_e      state, state_nxt;
    logic [8:0]  wptr;
    logic [31:0] word_reg;
    logic [31:0] enc_word;
    logic        enc_known;
    logic        accept;
    logic        writing;

    instr_field_encoder u_enc (
        .mnem   (req_mnem),
        .rs     (req_rs),
        .rt     (req_rt),
        .rd     (req_rd),
        .shamt  (req_shamt),
        .imm    (req_imm),
        .target (req_target),
        .word   (enc_word),
        .known  (enc_known)
    );

    assign accept  = req_valid && (state == ST_IDLE);
    assign writing = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: state_nxt = (accept && enc_known) ? ST_WR0 : ST_IDLE;
            ST_WR0:  state_nxt = ST_WR1;
            ST_WR1:  state_nxt = ST_WR2;
            ST_WR2:  state_nxt = ST_WR3;
            ST_WR3:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == ST_IDLE);
        mem_we     = writing;
        mem_addr   = writing ? wptr : '0;
        word_valid = (state == ST_WR3);
        case (state)
            ST_WR0:  mem_data = word_reg[31:24];
            ST_WR1:  mem_data = word_reg[23:16];
            ST_WR2:  mem_data = word_reg[15:8];
            ST_WR3:  mem_data = word_reg[7:0];
            default: mem_data = '0;
        endcase
    end

    // clear only acts in IDLE, so a same-cycle request still sees wptr=0 in WR0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr        <= '0;
            word_reg    <= '0;
            err_unknown <= 1'b0;
        end else begin
            err_unknown <= accept && !enc_known;
            if (writing)
                wptr <= wptr + 9'd1;
            else if (clear)
                wptr <= '0;
            if (accept && enc_known)
                word_reg <= enc_word;
        end
    end

    assign word_out = word_reg;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_mnem;
    logic [4:0]  req_rs, req_rt, req_rd, req_shamt;
    logic [15:0] req_imm;
    logic [25:0] req_target;
    logic        clear;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [7:0]  mem_data;
    logic [31:0] word_out;
    logic        word_valid;
    logic        err_unknown;

    int n_checks = 0;
    int n_fails  = 0;
    int exp_wptr = 0;

    instr_encoder_loader dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_mnem    (req_mnem),
        .req_rs      (req_rs),
        .req_rt      (req_rt),
        .req_rd      (req_rd),
        .req_shamt   (req_shamt),
        .req_imm     (req_imm),
        .req_target  (req_target),
        .clear       (clear),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .err_unknown (err_unknown)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input logic [5:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [4:0] sh,
                              input logic [15:0] imm, input logic [25:0] tgt);
        req_mnem = mn; req_rs = rs; req_rt = rt; req_rd = rd;
        req_shamt = sh; req_imm = imm; req_target = tgt;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 10 && req_ready !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        if (req_ready !== 1'b1) check_eq({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
    endtask

    // Called at a sampling point (1 time unit after a rising edge).
    task automatic write_word(input string tag, input logic [31:0] exp_word, input logic clr);
        logic [31:0] w;
        w = exp_word;
        wait_ready(tag);
        req_valid = 1'b1;
        clear = clr;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (clr) exp_wptr = 0;
        check_eq({tag, "_word_out"}, word_out, exp_word);
        for (int i = 0; i < 4; i++) begin
            check_eq({tag, "_we"}, 32'(mem_we), 32'd1);
            check_eq({tag, "_addr"}, 32'(mem_addr), 32'(exp_wptr));
            check_eq({tag, "_data"}, 32'(mem_data), 32'(w[31:24]));
            check_eq({tag, "_word_valid"}, 32'(word_valid), (i == 3) ? 32'd1 : 32'd0);
            check_eq({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
            w = w << 8;
            exp_wptr = (exp_wptr + 1) % 512;
            @(posedge clk); #1;
        end
        clear = 1'b0;
        check_eq({tag, "_ready_back"}, 32'(req_ready), 32'd1);
        check_eq({tag, "_we_idle"}, 32'(mem_we), 32'd0);
        check_eq({tag, "_wv_idle"}, 32'(word_valid), 32'd0);
    endtask

    task automatic quick_write();
        wait_ready("quick");
        set_fields(6'd20, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        exp_wptr = (exp_wptr + 4) % 512;
    endtask

    task automatic unknown_req(input logic [5:0] mn);
        set_fields(mn, 5'd1, 5'd2, 5'd3, 5'd0, 16'h1234, 26'h0);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("unk_err_pulse", 32'(err_unknown), 32'd1);
        check_eq("unk_we", 32'(mem_we), 32'd0);
        check_eq("unk_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        check_eq("unk_err_clear", 32'(err_unknown), 32'd0);
        check_eq("unk_we_after", 32'(mem_we), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        reset = 1'b1; req_valid = 1'b0; clear = 1'b0;
        set_fields(6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_we", 32'(mem_we), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_data", 32'(mem_data), 32'd0);
        check_eq("rst_word", word_out, 32'd0);
        check_eq("rst_wv", 32'(word_valid), 32'd0);
        check_eq("rst_err", 32'(err_unknown), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_ready", 32'(req_ready), 32'd1);

        // Directed encodings
        set_fields(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        write_word("addu", 32'h00221821, 1'b0);
        set_fields(6'd7, 5'd0, 5'd5, 5'd0, 5'd0, 16'hFFFF, 26'h0);
        write_word("addiu", 32'h2405FFFF, 1'b0);
        set_fields(6'd17, 5'd4, 5'd0, 5'd0, 5'd0, 16'h0003, 26'h0);
        write_word("bgez", 32'h04810003, 1'b0);
        set_fields(6'd18, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
        write_word("j", 32'h08000010, 1'b0);
        set_fields(6'd4, 5'd0, 5'd2, 5'd4, 5'd3, 16'h0, 26'h0);
        write_word("sll", 32'h000220C0, 1'b0);
        set_fields(6'd11, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0010, 26'h0);
        write_word("lw", 32'h8FA80010, 1'b0);
        set_fields(6'd19, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF);
        write_word("jal", 32'h0FFFFFFF, 1'b0);
        set_fields(6'd20, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        write_word("nop", 32'h00000000, 1'b0);

        // Unsupported codes: boundary 21 and max 63; pointer must not move
        unknown_req(6'd21);
        unknown_req(6'd63);
        set_fields(6'd10, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1234, 26'h0);
        write_word("lui_after_unk", 32'h3C011234, 1'b0);

        // Fill to 508, then wrap across 511 -> 0
        for (int k = 0; k < 200 && exp_wptr != 508; k++) quick_write();
        set_fields(6'd1, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0, 26'h0);
        write_word("subu_wrap", 32'h00E84823, 1'b0);
        set_fields(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        write_word("addu_post_wrap", 32'h00221821, 1'b0);

        // Reset during WR1
        set_fields(6'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("wr1_addr", 32'(mem_addr), 32'(exp_wptr + 1));
        reset = 1'b1;
        #1;
        check_eq("midrst_we", 32'(mem_we), 32'd0);
        check_eq("midrst_ready", 32'(req_ready), 32'd1);
        check_eq("midrst_word", word_out, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_wptr = 0;
        set_fields(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        write_word("addu_after_rst", 32'h00221821, 1'b0);

        // req_valid held high: one acceptance per 5 cycles
        set_fields(6'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        req_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (req_ready === 1'b1) acc++;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        exp_wptr = (exp_wptr + 12) % 512;
        check_eq("stream_accepts", 32'(acc), 32'd3);
        check_eq("stream_word", word_out, 32'h00221825);
        check_eq("stream_ready", 32'(req_ready), 32'd1);

        // clear + request with wptr=40; clear held through WR cycles is ignored
        for (int k = 0; k < 20 && exp_wptr != 40; k++) quick_write();
        set_fields(6'd16, 5'd3, 5'd4, 5'd0, 5'd0, 16'hFFFE, 26'h0);
        write_word("bne_clear", 32'h1464FFFE, 1'b1);
        set_fields(6'd9, 5'd2, 5'd6, 5'd0, 5'd0, 16'h00FF, 26'h0);
        write_word("ori_after_clear", 32'h344600FF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
